// File: rtl/cvtsw_pkg.sv
// Shared defaults and helpers for the round-robin int-to-float converter slice.
package cvtsw_pkg;

  localparam int DEF_INTN = 32;
  localparam int DEF_NEXP = 8;
  localparam int DEF_NSIG = 7;
  localparam int DEF_BIAS = (1 << (DEF_NEXP - 1)) - 1;
  localparam int FPW      = DEF_NEXP + DEF_NSIG + 1;

  // Requester index width; never narrower than one bit so a 1-requester build still has an ID.
  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cvtsw_rr_arb.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module cvtsw_rr_arb
  import cvtsw_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!grant_any && req[cand]) begin
        grant_any       = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/hp_cvtsw.sv
// Combinational signed integer to NEXP/NSIG float converter.
// Uses round-to-nearest-even. On exponent overflow, it saturates to infinity.
module hp_cvtsw #(
  parameter int INTN = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7,
  parameter int BIAS = (1 << (NEXP - 1)) - 1
) (
  input  logic [INTN-1:0]      value,
  output logic [NEXP+NSIG:0]   result,
  output logic                 inexact,
  output logic                 overflow
);

  localparam int EW   = INTN + NSIG + 1;
  localparam int EMAX = (1 << NEXP) - 1;

  logic            sign;
  logic [INTN-1:0] mag;
  logic [EW-1:0]   ext;
  logic [NSIG-1:0] frac;
  logic            guard;
  logic            sticky;
  logic            round_up;
  logic [NSIG:0]   rsum;
  int              msb;
  int              bexp;

  always_comb begin
    sign = value[INTN-1];
    mag  = sign ? (~value + 1'b1) : value;
    msb  = 0;
    for (int i = 0; i < INTN; i++) begin
      if (mag[i]) msb = i;
    end
    // Shift the hidden leading one out of the top so every remaining bit is fraction/guard/sticky.
    ext      = {mag, {(NSIG + 1){1'b0}}} << (INTN - msb);
    frac     = ext[EW-1 -: NSIG];
    guard    = ext[EW-1-NSIG];
    sticky   = |ext[EW-2-NSIG:0];
    round_up = guard & (sticky | frac[0]);
    rsum     = {1'b0, frac} + {{NSIG{1'b0}}, round_up};
    bexp     = msb + BIAS + int'(rsum[NSIG]);

    result   = '0;
    inexact  = 1'b0;
    overflow = 1'b0;
    if (mag != '0) begin
      if (bexp >= EMAX) begin
        overflow = 1'b1;
        inexact  = 1'b1;
        result   = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      end else begin
        inexact  = guard | sticky;
        result   = {sign, bexp[NEXP-1:0], rsum[NSIG-1:0]};
      end
    end
  end

endmodule

// File: rtl/cvtsw_rr_sched.sv
// Round-robin scheduler sharing one hp_cvtsw among NREQ requesters through a 2-stage stallable pipe.
// Optional CVTSW_STICKY_EN adds flag_clr and sticky_inexact/sticky_overflow accumulators.
module cvtsw_rr_sched
  import cvtsw_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int INTn = DEF_INTN,
  parameter int NEXP = DEF_NEXP,
  parameter int NSIG = DEF_NSIG,
  parameter int IDW  = idw(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*INTn-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [NEXP+NSIG:0]     resp_data,
  output logic [IDW-1:0]         resp_id,
  output logic                   resp_inexact,
  output logic                   resp_overflow,
`ifdef CVTSW_STICKY_EN
  input  logic                   flag_clr,
  output logic                   sticky_inexact,
  output logic                   sticky_overflow,
`endif
  output logic                   busy
);

  // Both channels transfer on the rising edge where valid && ready. A valid source
  // holds its payload until that edge, and valid never waits on ready.

  logic              s1_valid;
  logic [INTn-1:0]   s1_data;
  logic [IDW-1:0]    s1_id;
  logic              s2_valid;
  logic [IDW-1:0]    ptr;
  logic              s1_open;
  logic              s2_open;
  logic              accept;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic [INTn-1:0]   sel_data;
  logic [NEXP+NSIG:0] cvt_result;
  logic              cvt_inexact;
  logic              cvt_overflow;

  cvtsw_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  hp_cvtsw #(
    .INTN (INTn),
    .NEXP (NEXP),
    .NSIG (NSIG)
  ) u_cvt (
    .value    (s1_data),
    .result   (cvt_result),
    .inexact  (cvt_inexact),
    .overflow (cvt_overflow)
  );

  // Grant is computed without regard to space; space only gates ready and the pointer.
  assign s2_open    = !s2_valid || resp_ready;
  assign s1_open    = !s1_valid || s2_open;
  assign accept     = grant_any && s1_open;
  assign req_ready  = s1_open ? grant : '0;
  assign sel_data   = req_data[int'(grant_idx)*INTn +: INTn];
  assign resp_valid = s2_valid;
  assign busy       = s1_valid || s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // S1 reloads whenever it is open: either it was empty or its entry moves to S2 this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else if (s1_open) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= sel_data;
        s1_id   <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      resp_data     <= '0;
      resp_id       <= '0;
      resp_inexact  <= 1'b0;
      resp_overflow <= 1'b0;
    end else if (s2_open) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        resp_data     <= cvt_result;
        resp_id       <= s1_id;
        resp_inexact  <= cvt_inexact;
        resp_overflow <= cvt_overflow;
      end
    end
  end

`ifdef CVTSW_STICKY_EN
  logic resp_fire;
  assign resp_fire = s2_valid && resp_ready;

  // A flagged handshake in the same cycle as flag_clr leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_inexact  <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      sticky_inexact  <= (flag_clr ? 1'b0 : sticky_inexact)  | (resp_fire & resp_inexact);
      sticky_overflow <= (flag_clr ? 1'b0 : sticky_overflow) | (resp_fire & resp_overflow);
    end
  end
`endif

endmodule

// File: tb/tb_cvtsw_rr_sched.sv
// Scoreboard bench for cvtsw_rr_sched: arithmetic float reference, rotating-priority model, queue-based checking.
module tb_cvtsw_rr_sched;

  localparam int NREQ = 4;
  localparam int INTN = 32;
  localparam int NEXP = 8;
  localparam int NSIG = 7;
  localparam int BIAS = 127;
  localparam int IDW  = 2;
  localparam int FPW  = NEXP + NSIG + 1;
  localparam int EW   = IDW + 2 + FPW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*INTN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [FPW-1:0]       resp_data;
  logic [IDW-1:0]       resp_id;
  logic                 resp_inexact;
  logic                 resp_overflow;
  logic                 busy;
`ifdef CVTSW_STICKY_EN
  logic                 flag_clr;
  logic                 sticky_inexact;
  logic                 sticky_overflow;
`endif

  cvtsw_rr_sched #(
    .NREQ (NREQ),
    .INTn (INTN),
    .NEXP (NEXP),
    .NSIG (NSIG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_id       (resp_id),
    .resp_inexact  (resp_inexact),
    .resp_overflow (resp_overflow),
`ifdef CVTSW_STICKY_EN
    .flag_clr        (flag_clr),
    .sticky_inexact  (sticky_inexact),
    .sticky_overflow (sticky_overflow),
`endif
    .busy          (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]   exp_q[$];
  int              acc_cyc_q[$];
  int              acc_stall_q[$];
  int              acc_log[$];
  int              acc_cyc_log[$];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              stall_cnt = 0;
  int              acc_count = 0;
  int              mptr = 0;
  logic [NREQ-1:0] acc_flag;
  logic [NREQ-1:0] ovr_en;
  logic [FPW+1:0]  ovr_val [NREQ];
  bit              keep_busy;
  logic            m_sti;
  logic            m_sto;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion from the numeric value: returns {inexact, overflow, float}.
  function automatic logic [FPW+1:0] ref_cvt(input logic [31:0] v);
    longint m, q, r, half;
    int     e, sh, be;
    logic   s;
    s = v[31];
    m = longint'($signed(v));
    if (m < 0) m = -m;
    if (m == 0) return '0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    r = 0;
    if (e <= NSIG) begin
      q = m << (NSIG - e);
    end else begin
      sh   = e - NSIG;
      q    = m >> sh;
      r    = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
    end
    if (q == (longint'(1) << (NSIG + 1))) begin
      q = q >> 1;
      e++;
    end
    be = e + BIAS;
    if (be >= (1 << NEXP) - 1) return {1'b1, 1'b1, s, {NEXP{1'b1}}, {NSIG{1'b0}}};
    return {r != 0, 1'b0, s, be[NEXP-1:0], q[NSIG-1:0]};
  endfunction

  function automatic logic [31:0] rand_int();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = $urandom;
      1: begin
        v = 32'($urandom_range(0, 300));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: v = 32'h8000_0000;
      3: v = 32'h0;
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [FPW+1:0]  r;
    logic [EW-1:0]   item;
    bit              open;
    bit              hs;
    int              j, ac, as;
    if (!rst) begin
      cyc++;
      if (!resp_ready) stall_cnt++;
      open    = (exp_q.size() < 2) || resp_ready;
      exp_rdy = '0;
      if (open) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (mptr + k) % NREQ;
          if (req_valid[j] && exp_rdy == '0) exp_rdy[j] = 1'b1;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
`ifdef CVTSW_STICKY_EN
      chk("sticky_inexact", 32'(sticky_inexact), 32'(m_sti));
      chk("sticky_overflow", 32'(sticky_overflow), 32'(m_sto));
`endif
      hs   = 1'b0;
      item = '0;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got id %0d data %h, expected no response (cycle %0d)",
                   resp_id, resp_data, cyc);
        end else begin
          chk("resp", 32'({resp_id, resp_inexact, resp_overflow, resp_data}), 32'(exp_q[0]));
          if (resp_ready) begin
            hs   = 1'b1;
            item = exp_q.pop_front();
            ac   = acc_cyc_q.pop_front();
            as   = acc_stall_q.pop_front();
            if (as == stall_cnt) chk("latency", 32'(cyc - ac), 32'd2);
          end
        end
      end
`ifdef CVTSW_STICKY_EN
      m_sti = (flag_clr ? 1'b0 : m_sti) | (hs & item[FPW+1]);
      m_sto = (flag_clr ? 1'b0 : m_sto) | (hs & item[FPW]);
`endif
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          r = ovr_en[k] ? ovr_val[k] : ref_cvt(req_data[k*INTN +: INTN]);
          exp_q.push_back({IDW'(k), r});
          acc_cyc_q.push_back(cyc);
          acc_stall_q.push_back(stall_cnt);
          acc_log.push_back(k);
          acc_cyc_log.push_back(cyc);
          acc_count++;
          acc_flag[k] = 1'b1;
          mptr = (k + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        ovr_en[i]   = 1'b0;
        if (keep_busy) req_data[i*INTN +: INTN] = rand_int();
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int i, input logic [31:0] v, input bit use_ovr, input logic [FPW+1:0] ov);
    req_valid[i]              = 1'b1;
    req_data[i*INTN +: INTN]  = v;
    ovr_en[i]                 = use_ovr;
    ovr_val[i]                = ov;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((req_valid != '0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (req_valid != '0 || exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d results outstanding after %0d cycles, expected 0", exp_q.size(), budget);
    end
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n;
    n = 0;
    while (acc_count < target && n < budget) begin
      step();
      n++;
    end
    if (acc_count < target) begin
      checks++;
      failures++;
      $display("FAIL accepts: got %0d accepts, expected %0d", acc_count, target);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    acc_cyc_q.delete();
    acc_stall_q.delete();
    acc_log.delete();
    acc_cyc_log.delete();
    mptr     = 0;
    acc_flag = '0;
    ovr_en   = '0;
    m_sti    = 1'b0;
    m_sto    = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    req_valid = '0;
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    keep_busy  = 1'b0;
    for (int i = 0; i < NREQ; i++) ovr_val[i] = '0;
    clear_model();
`ifdef CVTSW_STICKY_EN
    flag_clr = 1'b0;
`endif
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_flags", 32'({resp_inexact, resp_overflow}), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two simultaneous requesters from ptr 0.
    issue(1, 32'hFFFF_FFC0, 1'b1, {1'b0, 1'b0, 16'hC280});
    issue(2, 32'd12345,     1'b1, {1'b1, 1'b0, 16'h4641});
    wait_drain(50);
    if (acc_log.size() >= 2) begin
      chk("pair_first", 32'(acc_log[0]), 32'd1);
      chk("pair_second", 32'(acc_log[1]), 32'd2);
      chk("pair_back_to_back", 32'(acc_cyc_log[1] - acc_cyc_log[0]), 32'd1);
    end

    // Single requester 0; latency is checked by the monitor.
    acc_log.delete();
    issue(0, 32'd128, 1'b1, {1'b0, 1'b0, 16'h4300});
    wait_drain(50);
    if (acc_log.size() >= 1) chk("single_id", 32'(acc_log[0]), 32'd0);

    // Rounding to a power of two and an exact small value.
    issue(0, 32'h7FFF_FFFF, 1'b1, {1'b1, 1'b0, 16'h4F00});
    issue(1, 32'd15,        1'b1, {1'b0, 1'b0, 16'h4170});
    wait_drain(50);
`ifdef CVTSW_STICKY_EN
    chk("sticky_set", 32'(sticky_inexact), 32'd1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("sticky_cleared", 32'(sticky_inexact), 32'd0);
`endif

    // All requesters continuously valid from ptr 0.
    do_reset();
    keep_busy = 1'b1;
    for (int i = 0; i < NREQ; i++) issue(i, rand_int(), 1'b0, '0);
    wait_accepts(8, 40);
    keep_busy = 1'b0;
    if (acc_log.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("rr_order", 32'(acc_log[k]), 32'(k % NREQ));
        chk("rr_one_per_cycle", 32'(acc_cyc_log[k] - acc_cyc_log[0]), 32'(k));
      end
    end
    wait_drain(50);

    // Consumer stalled: two results buffer, then requests are refused.
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) issue(i, rand_int(), 1'b0, '0);
    a0 = acc_count;
    repeat (5) step();
    chk("stall_accepts", 32'(acc_count - a0), 32'd2);
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    wait_drain(100);

    // Random traffic with random back-pressure.
    repeat (400) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) issue(i, rand_int(), 1'b0, '0);
      end
      resp_ready = ($urandom_range(0, 9) < 7);
    end
    resp_ready = 1'b1;
    wait_drain(200);

    // Reset with both stages full discards everything and restores ptr 0.
    resp_ready = 1'b0;
    for (int i = 1; i < NREQ; i++) issue(i, rand_int(), 1'b0, '0);
    repeat (4) step();
    chk("prefull_resp_valid", 32'(resp_valid), 32'd1);
    chk("prefull_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    clear_model();
    issue(3, rand_int(), 1'b0, '0);
    issue(0, rand_int(), 1'b0, '0);
    #1;
    chk("midrst_ptr_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    wait_drain(50);
    if (acc_log.size() >= 2) begin
      chk("post_rst_first", 32'(acc_log[0]), 32'd0);
      chk("post_rst_second", 32'(acc_log[1]), 32'd3);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
